// File: rtl/ps2_kbd_pia.sv
// PS/2 set-2 keyboard front end: frame receiver, scancode-to-ASCII decoder and
// character FIFO, exposed to the CPU as the KBD/KBDCR register pair.
module ps2_kbd_pia #(
  parameter int CLK_HZ     = 14000000,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       cs,
  input  logic       rd_en,
  input  logic       address,
  output logic [7:0] dout,
  output logic       key_ready,
  output logic       frame_err
);

  localparam longint TO_CYC_L = longint'(CLK_HZ) * longint'(TIMEOUT_US) / longint'(1000000);
  localparam int     TO_CYC   = int'(TO_CYC_L);
  localparam int     TO_W     = $clog2(TO_CYC + 1);
  localparam int     AW       = $clog2(FIFO_DEPTH);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]     CNT_MAX = (AW+1)'(FIFO_DEPTH);

  // ---------------- input synchronisers and clock glitch filter ----------------
  logic [1:0] clk_sync;
  logic [1:0] din_sync;
  logic [3:0] clk_hist;
  logic       clk_filt;
  logic       fall;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      din_sync <= 2'b11;
      clk_hist <= 4'hF;
      clk_filt <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      din_sync <= {din_sync[0], ps2_din};
      clk_hist <= {clk_hist[2:0], clk_sync[1]};
      fall     <= 1'b0;
      if (clk_hist == 4'hF) begin
        clk_filt <= 1'b1;
      end else if (clk_hist == 4'h0) begin
        clk_filt <= 1'b0;
        fall     <= clk_filt;
      end
    end
  end

  // ---------------- frame receiver ----------------
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            byte_vld;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      to_cnt    <= '0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        // Stalled mid-frame: abandon it so the next start bit resynchronises.
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!din_sync[1]) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {din_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= din_sync[1];
            state   <= STOP;
          end
          STOP: begin
            if ((^{shreg, par_bit}) && din_sync[1]) byte_vld  <= 1'b1;
            else                                    frame_err <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // ---------------- scancode translation ----------------
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic sh, input logic ct);
    logic [7:0] a;
    logic       ok;
    logic       letter;
    a      = 8'h00;
    ok     = 1'b1;
    letter = 1'b1;
    case (code)
      8'h1C: a = "A";  8'h32: a = "B";  8'h21: a = "C";  8'h23: a = "D";
      8'h24: a = "E";  8'h2B: a = "F";  8'h34: a = "G";  8'h33: a = "H";
      8'h43: a = "I";  8'h3B: a = "J";  8'h42: a = "K";  8'h4B: a = "L";
      8'h3A: a = "M";  8'h31: a = "N";  8'h44: a = "O";  8'h4D: a = "P";
      8'h15: a = "Q";  8'h2D: a = "R";  8'h1B: a = "S";  8'h2C: a = "T";
      8'h3C: a = "U";  8'h2A: a = "V";  8'h1D: a = "W";  8'h22: a = "X";
      8'h35: a = "Y";  8'h1A: a = "Z";
      default: letter = 1'b0;
    endcase
    if (!letter) begin
      case (code)
        8'h16: a = sh ? "!" : "1";
        8'h1E: a = sh ? "@" : "2";
        8'h26: a = sh ? "#" : "3";
        8'h25: a = sh ? "$" : "4";
        8'h2E: a = sh ? "%" : "5";
        8'h36: a = sh ? "^" : "6";
        8'h3D: a = sh ? "&" : "7";
        8'h3E: a = sh ? "*" : "8";
        8'h46: a = sh ? "(" : "9";
        8'h45: a = sh ? ")" : "0";
        8'h41: a = sh ? "<" : ",";
        8'h49: a = sh ? ">" : ".";
        8'h4A: a = sh ? "?" : "/";
        8'h4C: a = sh ? ":" : ";";
        8'h52: a = sh ? 8'h22 : 8'h27;
        8'h4E: a = sh ? "_" : "-";
        8'h55: a = sh ? "+" : "=";
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h5F;
        8'h76: a = 8'h1B;
        default: ok = 1'b0;
      endcase
    end
    // The Apple-1 has no lowercase, so shift never changes a letter; ctrl folds it to a control code.
    if (letter && ct) a = a & 8'h1F;
    return {ok, a};
  endfunction

  logic       ext;
  logic       brk;
  logic       shift_l;
  logic       shift_r;
  logic       ctrl;
  logic       push_vld;
  logic [7:0] push_dat;
  logic [8:0] xl;

  assign xl = xlate(shreg, shift_l | shift_r, ctrl);

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      ctrl     <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= 8'h00;
    end else begin
      push_vld <= 1'b0;
      if (byte_vld) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && shreg == 8'h12) shift_l <= !brk;
          if (!ext && shreg == 8'h59) shift_r <= !brk;
          if (shreg == 8'h14)         ctrl    <= !brk;
          if (!ext && !brk && xl[8]) begin
            push_vld <= 1'b1;
            push_dat <= xl[7:0] | 8'h80;
          end
        end
      end
    end
  end

  // ---------------- character FIFO and register interface ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          rd_cr;
  logic          overflow;
  logic [7:0]    last_kbd;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign pop   = cs && rd_en && !address && !empty;
  assign rd_cr = cs && rd_en && address;
  assign push  = push_vld && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (!push && pop) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk14) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      key_ready <= 1'b0;
      overflow  <= 1'b0;
      last_kbd  <= 8'h00;
    end else begin
      count     <= count_nxt;
      key_ready <= (count_nxt != '0);
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr     <= rptr + AW'(1);
        last_kbd <= mem[rptr];
      end
      if (push_vld && full && !pop) overflow <= 1'b1;
      else if (rd_cr)               overflow <= 1'b0;
    end
  end

  always_comb begin
    if (address)     dout = {key_ready, overflow, 6'b000000};
    else if (!empty) dout = mem[rptr];
    else             dout = last_kbd;
  end

endmodule
